// File: rtl/charging_station_pkg.sv
// Shared types and constants for the coin-operated charging station:
// FSM state encoding, coin codes and the BCD M:SS credit each coin buys.
package charging_station_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CHARGING = 1'b1
  } state_t;

  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_2MIN = 3'd1;
  localparam logic [2:0] COIN_4MIN = 3'd2;
  localparam logic [2:0] COIN_6MIN = 3'd3;
  localparam logic [2:0] COIN_8MIN = 3'd4;

  localparam logic [11:0] TIME_ZERO    = 12'h000;
  localparam logic [11:0] TIME_ONE_SEC = 12'h001;
  localparam logic [11:0] CREDIT_2MIN  = 12'h200;
  localparam logic [11:0] CREDIT_4MIN  = 12'h400;
  localparam logic [11:0] CREDIT_6MIN  = 12'h600;
  localparam logic [11:0] CREDIT_8MIN  = 12'h800;

  function automatic logic coin_valid(input logic [2:0] coin);
    return (coin == COIN_2MIN) || (coin == COIN_4MIN) ||
           (coin == COIN_6MIN) || (coin == COIN_8MIN);
  endfunction

  function automatic logic [11:0] coin_credit(input logic [2:0] coin);
    logic [11:0] credit;
    case (coin)
      COIN_2MIN: credit = CREDIT_2MIN;
      COIN_4MIN: credit = CREDIT_4MIN;
      COIN_6MIN: credit = CREDIT_6MIN;
      COIN_8MIN: credit = CREDIT_8MIN;
      default:   credit = TIME_ZERO;
    endcase
    return credit;
  endfunction

endpackage

// File: rtl/charging_station_bcd_time_down.sv
// BCD M:SS down-counter: load has priority over decrement, never goes below
// 0:00, and flags when the next decrement will land on 0:00.
module bcd_time_down
  import charging_station_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_load,
  input  logic [11:0] i_load_val,
  input  logic        i_dec,
  output logic [11:0] o_time,
  output logic        o_zero_next
);

  logic [11:0] r_time;
  logic [3:0]  w_min;
  logic [3:0]  w_tens;
  logic [3:0]  w_sec;
  logic [11:0] w_time_n;

  always_comb begin
    w_min    = r_time[11:8];
    w_tens   = r_time[7:4];
    w_sec    = r_time[3:0];
    w_time_n = r_time;
    if (i_load) begin
      w_time_n = i_load_val;
    end else if (i_dec && (r_time != TIME_ZERO)) begin
      // borrow ripples sec -> tens -> min
      if (w_sec == 4'd0) begin
        w_sec = 4'd9;
        if (w_tens == 4'd0) begin
          w_tens = 4'd5;
          w_min  = w_min - 4'd1;
        end else begin
          w_tens = w_tens - 4'd1;
        end
      end else begin
        w_sec = w_sec - 4'd1;
      end
      w_time_n = {w_min, w_tens, w_sec};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_time <= TIME_ZERO;
    end else begin
      r_time <= w_time_n;
    end
  end

  assign o_time      = r_time;
  assign o_zero_next = (r_time == TIME_ONE_SEC);

endmodule

// File: rtl/charging_station.sv
// Coin-operated charging station: coin edge detection, IDLE/CHARGING FSM and
// seconds prescaler driving a BCD M:SS countdown of the purchased time.
module charging_station
  import charging_station_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ModeEnable,
  input  logic [2:0]  Coin,
  output logic [11:0] PresentTime,
  output logic        Charging,
  output logic        CoinReject
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);

  state_t        r_state;
  state_t        w_state_n;
  logic [2:0]    r_coin_prev;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_n;
  logic          r_coin_reject;
  logic          w_reject;
  logic          w_load;
  logic          w_dec;
  logic          w_zero_next;
  logic          w_coin_event;
  logic [11:0]   w_time;

  assign w_coin_event = (Coin != COIN_NONE) && (r_coin_prev == COIN_NONE);

  always_comb begin
    w_state_n = r_state;
    w_presc_n = r_presc;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    w_reject  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_event) begin
          if (ModeEnable && coin_valid(Coin)) begin
            w_load    = 1'b1;
            w_presc_n = '0;
            w_state_n = ST_CHARGING;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_CHARGING: begin
        // any coin during a session is refused, even on the final second
        w_reject = w_coin_event;
        if (ModeEnable) begin
          if (r_presc == PRESC_TC) begin
            w_presc_n = '0;
            w_dec     = 1'b1;
            if (w_zero_next) begin
              w_state_n = ST_IDLE;
            end
          end else begin
            w_presc_n = r_presc + 1'b1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_coin_prev   <= COIN_NONE;
      r_presc       <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_coin_prev   <= Coin;
      r_presc       <= w_presc_n;
      r_coin_reject <= w_reject;
    end
  end

  bcd_time_down u_time (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_load      (w_load),
    .i_load_val  (coin_credit(Coin)),
    .i_dec       (w_dec),
    .o_time      (w_time),
    .o_zero_next (w_zero_next)
  );

  assign PresentTime = w_time;
  assign Charging    = (r_state == ST_CHARGING);
  assign CoinReject  = r_coin_reject;

endmodule

// File: tb/tb_charging_station.sv
// Scoreboard bench for charging_station: stimulus pushes expected post-edge
// outputs (integer-seconds model plus hand constants), a monitor compares.
module tb_charging_station;

  localparam int TPS = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ModeEnable = 1'b0;
  logic [2:0]  Coin = 3'd0;
  logic [11:0] PresentTime;
  logic        Charging;
  logic        CoinReject;

  charging_station #(.TICKS_PER_SEC(TPS)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ModeEnable  (ModeEnable),
    .Coin        (Coin),
    .PresentTime (PresentTime),
    .Charging    (Charging),
    .CoinReject  (CoinReject)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] t;
    logic        chg;
    logic        rej;
    bit          hand;
    logic [11:0] h_t;
    logic        h_chg;
    logic        h_rej;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int   m_secs = 0;
  bit   m_chg = 0;
  int   m_presc = 0;
  logic [2:0] m_prev = 3'd0;

  task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_chg = 0; m_presc = 0; m_prev = 3'd0;
  endtask

  task automatic step(input logic mode, input logic [2:0] coin,
                      input bit hand = 0, input logic [11:0] h_t = 12'h000,
                      input logic h_chg = 1'b0, input logic h_rej = 1'b0,
                      input string nm = "run");
    exp_t e;
    bit ev;
    bit rej;
    ModeEnable = mode;
    Coin = coin;
    ev = (coin != 3'd0) && (m_prev == 3'd0);
    rej = 0;
    if (!m_chg) begin
      if (ev) begin
        if (mode && coin >= 3'd1 && coin <= 3'd4) begin
          m_secs = int'(coin) * 120;
          m_chg = 1;
          m_presc = 0;
        end else begin
          rej = 1;
        end
      end
    end else begin
      if (ev) rej = 1;
      if (mode) begin
        if (m_presc == TPS - 1) begin
          m_presc = 0;
          m_secs--;
          if (m_secs == 0) m_chg = 0;
        end else begin
          m_presc++;
        end
      end
    end
    m_prev = coin;
    e.t = to_bcd(m_secs);
    e.chg = m_chg;
    e.rej = rej;
    e.hand = hand;
    e.h_t = h_t;
    e.h_chg = h_chg;
    e.h_rej = h_rej;
    e.name = nm;
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    @(negedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.name, "_time"}, PresentTime, e.t);
      cmp({e.name, "_chg"}, {11'd0, Charging}, {11'd0, e.chg});
      cmp({e.name, "_rej"}, {11'd0, CoinReject}, {11'd0, e.rej});
      if (e.hand) begin
        cmp({e.name, "_hand_time"}, PresentTime, e.h_t);
        cmp({e.name, "_hand_chg"}, {11'd0, Charging}, {11'd0, e.h_chg});
        cmp({e.name, "_hand_rej"}, {11'd0, CoinReject}, {11'd0, e.h_rej});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    #1 Reset = 1'b1;
    #1;
    cmp("reset_time", PresentTime, 12'h000);
    cmp("reset_chg", {11'd0, Charging}, 12'h000);
    cmp("reset_rej", {11'd0, CoinReject}, 12'h000);
    model_reset();
    @(negedge Clk);
    #1 Reset = 1'b0;

    // coin 1 held from the first edge for 120 cycles
    step(1, 3'd1, 1, 12'h200, 1, 0, "first_load");
    step(1, 3'd1, 1, 12'h159, 1, 0, "first_dec");
    for (int i = 3; i <= 120; i++) step(1, 3'd1);
    step(1, 3'd0, 1, 12'h000, 0, 0, "session_end");
    step(1, 3'd0, 1, 12'h000, 0, 0, "idle_stays");

    step(1, 3'd3, 1, 12'h600, 1, 0, "coin3_load");
    step(1, 3'd0, 1, 12'h559, 1, 0, "coin3_dec");
    step(1, 3'd1, 1, 12'h558, 1, 1, "busy_reject");
    step(1, 3'd1, 1, 12'h557, 1, 0, "reject_once");
    step(1, 3'd0, 1, 12'h556, 1, 0, "after_reject");

    for (int i = 0; i < 1000 && m_secs != 60; i++) step(1, 3'd0);
    for (int i = 0; i < 10; i++) step(0, 3'd0, 1, 12'h100, 1, 0, "pause_hold");
    step(1, 3'd0, 1, 12'h059, 1, 0, "resume");
    step(0, 3'd2, 1, 12'h059, 1, 1, "paused_coin");
    step(0, 3'd0, 1, 12'h059, 1, 0, "paused_quiet");
    step(1, 3'd0, 1, 12'h058, 1, 0, "resume2");

    for (int i = 0; i < 1000 && m_secs != 1; i++) step(1, 3'd0);
    step(1, 3'd4, 1, 12'h000, 0, 1, "final_edge_coin");
    step(1, 3'd0, 1, 12'h000, 0, 0, "idle_after_end");
    step(1, 3'd6, 1, 12'h000, 0, 1, "invalid_coin");
    step(1, 3'd0, 1, 12'h000, 0, 0, "invalid_quiet");
    step(0, 3'd1, 1, 12'h000, 0, 1, "closed_coin");
    step(1, 3'd0, 1, 12'h000, 0, 0, "closed_quiet");

    step(1, 3'd2, 1, 12'h400, 1, 0, "coin2_load");
    for (int i = 0; i < 1000 && m_secs != 84; i++) step(1, 3'd0);
    step(1, 3'd0, 1, 12'h123, 1, 0, "at_1_23");
    drain();

    Reset = 1'b1;
    #1;
    cmp("midreset_time", PresentTime, 12'h000);
    cmp("midreset_chg", {11'd0, Charging}, 12'h000);
    cmp("midreset_rej", {11'd0, CoinReject}, 12'h000);
    model_reset();
    @(negedge Clk);
    Coin = 3'd1;
    #1 Reset = 1'b0;
    step(1, 3'd1, 1, 12'h200, 1, 0, "held_through_reset");
    step(1, 3'd1, 1, 12'h159, 1, 0, "held_dec");
    drain();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/charging_station.md
CHARGING_STATION -- requirements
Module: charging_station

Interface
REQ-001 SHALL provide parameter TICKS_PER_SEC, default 1, meaning Clk cycles per countdown second (1 for simulation, larger for silicon).
REQ-002 SHALL provide port Clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port ModeEnable  input  1  station enable; 0 = paused/closed.
REQ-005 SHALL provide port Coin  input  3  coin code; 0 = no coin.
REQ-006 SHALL provide port PresentTime  output  12  remaining time, BCD M:SS; [11:8] minutes, [7:4] tens of seconds, [3:0] seconds.
REQ-007 SHALL provide port Charging  output  1  high while a session is active, including while paused.
REQ-008 SHALL provide port CoinReject  output  1  one-cycle pulse when a coin event is refused.

Function
REQ-009 SHALL register Coin every cycle into CoinPrev; a coin event is Coin != 0 and CoinPrev == 0, so a held coin counts once.
REQ-010 SHALL map coin codes to credit: 1 -> 2:00, 2 -> 4:00, 3 -> 6:00, 4 -> 8:00; codes 5-7 are invalid.
REQ-011 SHALL use states IDLE and CHARGING; a session paused by ModeEnable=0 stays in CHARGING.
REQ-012 In IDLE, a valid coin event with ModeEnable=1 SHALL load the credit into PresentTime on the same edge, enter CHARGING and clear the prescaler.
REQ-013 SHALL pulse CoinReject for exactly one cycle on a coin event in CHARGING, with an invalid code, or while ModeEnable=0; PresentTime SHALL stay unchanged.
REQ-014 In CHARGING with ModeEnable=1, the prescaler SHALL count 0..TICKS_PER_SEC-1; on its terminal count PresentTime SHALL decrement by one second.
REQ-015 SHALL decrement in BCD: seconds 0 wraps to 9 with a borrow from tens; tens 0 wraps to 5 with a borrow from minutes; no digit ever exceeds its range (min <= 9, tens <= 5, sec <= 9).
REQ-016 A decrement from 0:01 to 0:00 SHALL return the block to IDLE on the same edge, with Charging low from the next cycle.
REQ-017 ModeEnable=0 SHALL freeze both the prescaler and PresentTime; the countdown SHALL resume from the frozen value when ModeEnable returns to 1.
REQ-018 In IDLE, PresentTime SHALL be 0:00 (12'h000) and Charging SHALL be 0.
REQ-019 A coin event on the same edge as the final decrement SHALL be rejected, because the state is still CHARGING.

Reset
REQ-020 Asserting Reset SHALL immediately force IDLE, PresentTime=12'h000, Charging=0, CoinReject=0, prescaler=0 and CoinPrev=0, including mid-session; any remaining credit is lost.
REQ-021 A coin held through reset release SHALL count as a coin event on the first active edge, because CoinPrev resets to 0.

Structure
REQ-022 SHALL put the state encoding (IDLE, CHARGING), coin code constants and the credit BCD constants (12'h200, 12'h400, 12'h600, 12'h800) in a shared package charging_station_pkg.
REQ-023 SHALL implement the BCD M:SS down-counter (load, decrement enable, zero-next flag) as one sub-module bcd_time_down; the FSM, coin detection and prescaler stay in the top module.

Verification
REQ-024 Reset, then ModeEnable=1 and Coin=1 held from the first edge -> PresentTime=12'h200 after one edge, 12'h159 after one more, Charging=1.
REQ-025 Coin=1 held for 1200 ns at 10 ns clock, TICKS_PER_SEC=1 -> PresentTime reaches 12'h000 after 120 decrements, Charging=0; the held coin does not restart a session.
REQ-026 During a session, Coin 0 -> 1 -> CoinReject is a single one-cycle pulse and the countdown is unaffected.
REQ-027 At 1:00, ModeEnable=0 for 10 cycles -> PresentTime holds 12'h100; after re-enable the next value is 12'h059.
REQ-028 Coin=3 in IDLE -> 12'h600; Coin=6 in IDLE -> CoinReject pulse and PresentTime stays 12'h000.
REQ-029 Reset asserted at 1:23 -> PresentTime=12'h000 and Charging=0 with no clock edge required.
